// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the 5-stage LC-3b pipeline.
//
// Takes the EX/MEM register contents, performs data-memory reads/writes over
// a request/response handshake (dmem_resp is a one-cycle completion pulse),
// stalls upstream until the final access completes, then loads MEM/WB.
//
// Build option: define MEM_STAGE_INDIRECT_EN to enable the two-access
// LDI/STI sequence (FIRST -> SECOND). Without it, LDI/STI complete
// immediately as no-ops that do not write the register file.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   mem_valid_in                 EX/MEM holds a live instruction
//   mem_opcode_in                LC-3b opcode
//   mem_alu_in                   ALU result / effective address
//   mem_st_data_in               store source value
//   mem_dest_in, mem_ld_reg_in   destination register and write enable
//   dmem_rdata, dmem_resp        data-memory read data and completion pulse
//   dmem_address/read/write      data-memory request
//   dmem_byte_enable, dmem_wdata write lanes and data
//   mem_stall                    hold all upstream stages
//   mem_fwd_data                 forwarding value for EX
//   wb_valid_out/data/dest/ld_reg_out  MEM/WB register
module mem_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid_in,
  input  logic [3:0]  mem_opcode_in,
  input  logic [15:0] mem_alu_in,
  input  logic [15:0] mem_st_data_in,
  input  logic [2:0]  mem_dest_in,
  input  logic        mem_ld_reg_in,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_wdata,
  output logic        mem_stall,
  output logic [15:0] mem_fwd_data,
  output logic        wb_valid_out,
  output logic [15:0] wb_data_out,
  output logic [2:0]  wb_dest_out,
  output logic        wb_ld_reg_out
);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  logic        is_mem;
  logic        is_ind;
  logic        is_load;
  logic        is_byte;
  logic        access;     // this op performs memory accesses
  logic        in_second;  // second (pointer-target) access of LDI/STI
  logic        nop_ind;    // LDI/STI retired without effect
  logic        req;
  logic        rd_req;
  logic        done;
  logic [15:0] ptr_addr;
  logic [15:0] acc_addr;
  logic [15:0] load_res;

  logic        wb_valid_q, wb_valid_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic [2:0]  wb_dest_q, wb_dest_d;
  logic        wb_ld_reg_q, wb_ld_reg_d;

  assign is_mem  = mem_valid_in &
                   ((mem_opcode_in == OP_LDB) || (mem_opcode_in == OP_STB) ||
                    (mem_opcode_in == OP_LDR) || (mem_opcode_in == OP_STR) ||
                    (mem_opcode_in == OP_LDI) || (mem_opcode_in == OP_STI));
  // Within the memory-op set: bit3 marks indirect, bit0 marks stores,
  // and bits[3:2]==00 marks byte ops.
  assign is_ind  = mem_opcode_in[3];
  assign is_load = ~mem_opcode_in[0];
  assign is_byte = ~mem_opcode_in[3] & ~mem_opcode_in[2];

`ifdef MEM_STAGE_INDIRECT_EN
  typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} state_e;
  state_e      state_q;
  logic [15:0] ptr_q;

  assign in_second = (state_q == SECOND);
  assign access    = is_mem;
  assign ptr_addr  = ptr_q;
  assign nop_ind   = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FIRST;
      ptr_q   <= 16'h0000;
    end else if (req && dmem_resp) begin
      if (in_second) begin
        state_q <= FIRST;
      end else if (is_ind) begin
        state_q <= SECOND;
        ptr_q   <= dmem_rdata;
      end
    end
  end
`else
  assign in_second = 1'b0;
  assign access    = is_mem & ~is_ind;
  assign ptr_addr  = 16'h0000;
  assign nop_ind   = is_mem & is_ind;
`endif

  // Requests exist only while out of reset, so a stray response during or
  // just after reset cannot complete anything.
  assign req    = access & reset_n;
  assign done   = req & dmem_resp & (in_second | ~is_ind);
  assign rd_req = in_second ? is_load : (is_load | is_ind);

  assign acc_addr         = in_second ? ptr_addr : mem_alu_in;
  assign dmem_address     = {acc_addr[15:1], 1'b0};
  assign dmem_read        = req & rd_req;
  assign dmem_write       = req & ~rd_req;
  assign dmem_wdata       = is_byte ? {mem_st_data_in[7:0], mem_st_data_in[7:0]}
                                    : mem_st_data_in;
  assign dmem_byte_enable = !dmem_write ? 2'b00 :
                            !is_byte    ? 2'b11 :
                            (mem_alu_in[0] ? 2'b10 : 2'b01);
  assign mem_stall        = req & ~done;

  always_comb begin
    load_res = dmem_rdata;
    if (!in_second && is_byte)
      load_res = {8'h00, mem_alu_in[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
  end

  assign mem_fwd_data = (done && is_load) ? load_res : mem_alu_in;

  always_comb begin
    wb_valid_d  = mem_valid_in;
    wb_data_d   = (done && is_load) ? load_res : mem_alu_in;
    wb_dest_d   = mem_dest_in;
    wb_ld_reg_d = mem_ld_reg_in & ~nop_ind;
    if (mem_stall) begin
      wb_valid_d  = 1'b0;
      wb_ld_reg_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid_q  <= 1'b0;
      wb_data_q   <= 16'h0000;
      wb_dest_q   <= 3'd0;
      wb_ld_reg_q <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_ld_reg_q <= wb_ld_reg_d;
    end
  end

  assign wb_valid_out  = wb_valid_q;
  assign wb_data_out   = wb_data_q;
  assign wb_dest_out   = wb_dest_q;
  assign wb_ld_reg_out = wb_ld_reg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized ops with a
// scoreboard on the MEM/WB register and direct checks on the request side.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid_in;
  logic [3:0]  mem_opcode_in;
  logic [15:0] mem_alu_in;
  logic [15:0] mem_st_data_in;
  logic [2:0]  mem_dest_in;
  logic        mem_ld_reg_in;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic        mem_stall;
  logic [15:0] mem_fwd_data;
  logic        wb_valid_out;
  logic [15:0] wb_data_out;
  logic [2:0]  wb_dest_out;
  logic        wb_ld_reg_out;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid_in(mem_valid_in), .mem_opcode_in(mem_opcode_in),
    .mem_alu_in(mem_alu_in), .mem_st_data_in(mem_st_data_in),
    .mem_dest_in(mem_dest_in), .mem_ld_reg_in(mem_ld_reg_in),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .mem_stall(mem_stall), .mem_fwd_data(mem_fwd_data),
    .wb_valid_out(wb_valid_out), .wb_data_out(wb_data_out),
    .wb_dest_out(wb_dest_out), .wb_ld_reg_out(wb_ld_reg_out)
  );

`ifdef MEM_STAGE_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  localparam logic [3:0] LDB = 4'b0010, STB = 4'b0011, LDR = 4'b0110;
  localparam logic [3:0] STR = 4'b0111, LDI = 4'b1010, STI = 4'b1011;
  localparam logic [3:0] ADD = 4'b0001;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  dest;
    logic        ld;
  } wb_t;

  wb_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: pops one expected MEM/WB record per valid writeback.
  always @(negedge clk) begin
    if (wb_valid_out) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid_out), 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        $display("wb: data=%h dest=%0d ld=%0b (exp data=%h dest=%0d ld=%0b)",
                 wb_data_out, wb_dest_out, wb_ld_reg_out, e.data, e.dest, e.ld);
        check("wb_data", 32'(wb_data_out), 32'(e.data));
        check("wb_dest", 32'(wb_dest_out), 32'(e.dest));
        check("wb_ld_reg", 32'(wb_ld_reg_out), 32'(e.ld));
      end
    end
  end

  // Called at posedge+1. Drives one instruction, acts as the memory with the
  // given response latencies, and returns at posedge+1 after its completion.
  task automatic run_op(input logic v, input logic [3:0] op, input logic [15:0] alu,
                        input logic [15:0] st, input logic [2:0] dest, input logic ldr,
                        input int lat1, input logic [15:0] rd1,
                        input int lat2, input logic [15:0] rd2);
    bit  memop = v && (op inside {LDB, STB, LDR, STR, LDI, STI});
    bit  ind   = (op == LDI) || (op == STI);
    bit  ld    = (op == LDB) || (op == LDR) || (op == LDI);
    bit  bytes = (op == LDB) || (op == STB);
    int  nacc  = !memop ? 0 : (ind ? (IND_EN ? 2 : 0) : 1);
    int  stalls = 0;
    int  exp_stalls = (nacc == 0) ? 0 : (nacc == 1 ? lat1 : lat1 + 1 + lat2);
    logic [15:0] res;
    wb_t e;

    if (op == LDB) res = (rd1 >> (alu[0] ? 8 : 0)) & 16'h00FF;
    else if (op == LDI) res = rd2;
    else res = rd1;

    e.data = (ld && nacc > 0) ? res : alu;
    e.dest = dest;
    e.ld   = ldr && !(ind && !IND_EN);
    if (v) exp_q.push_back(e);

    mem_valid_in = v; mem_opcode_in = op; mem_alu_in = alu;
    mem_st_data_in = st; mem_dest_in = dest; mem_ld_reg_in = ldr;

    if (nacc == 0) begin
      dmem_resp  = 1'($urandom_range(0, 1));   // stray response must be ignored
      dmem_rdata = 16'($urandom);
      #1;
      check("noreq_rw", {30'd0, dmem_read, dmem_write}, 32'd0);
      check("nomem_fwd", 32'(mem_fwd_data), 32'(alu));
      if (mem_stall) stalls++;
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end else begin
      for (int a = 0; a < nacc; a++) begin
        int          lat = (a == 0) ? lat1 : lat2;
        logic [15:0] ea  = (a == 0) ? alu : rd1;
        bit          erd = (a == 0) ? (ld || ind) : ld;
        for (int c = 0; c <= lat; c++) begin
          dmem_resp  = (c == lat);
          dmem_rdata = (c == lat) ? ((a == 0) ? rd1 : rd2) : 16'($urandom);
          #1;
          check("req_addr", 32'(dmem_address), 32'(ea & 16'hFFFE));
          check("req_rw", {30'd0, dmem_read, dmem_write}, {30'd0, erd, !erd});
          if (!erd && c == 0) begin
            check("wr_be", 32'(dmem_byte_enable),
                  bytes ? (alu[0] ? 32'd2 : 32'd1) : 32'd3);
            check("wr_data", 32'(dmem_wdata),
                  bytes ? 32'(st & 16'h00FF) * 32'h0101 : 32'(st));
          end
          if (c == lat && a == nacc - 1)
            check("fwd_done", 32'(mem_fwd_data), 32'(ld ? res : alu));
          if (mem_stall) stalls++;
          @(posedge clk); #1;
          dmem_resp = 1'b0;
        end
      end
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; mem_valid_in = 1'b0; mem_opcode_in = 4'd0; mem_alu_in = 16'd0;
    mem_st_data_in = 16'd0; mem_dest_in = 3'd0; mem_ld_reg_in = 1'b0;
    dmem_rdata = 16'd0; dmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_valid", 32'(wb_valid_out), 32'd0);
    check("rst_wb_data", 32'(wb_data_out), 32'd0);
    check("rst_wb_ld_reg", 32'(wb_ld_reg_out), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    reset_n = 1'b1;

    // Directed cases.
    run_op(1, ADD, 16'h1234, 16'h0, 3'd3, 1, 0, 16'h0, 0, 16'h0);
    run_op(1, LDR, 16'h3001, 16'h0, 3'd1, 1, 2, 16'hBEEF, 0, 16'h0);
    run_op(1, LDB, 16'h3001, 16'h0, 3'd2, 1, 1, 16'hBEEF, 0, 16'h0);
    run_op(1, STB, 16'h3000, 16'h12AB, 3'd0, 0, 0, 16'h0, 0, 16'h0);
    run_op(1, LDI, 16'h4000, 16'h0, 3'd4, 1, 1, 16'h5002, 2, 16'h7777);
    run_op(1, STI, 16'h4000, 16'h4321, 3'd5, 0, 0, 16'h5002, 1, 16'h0);

    // Reset in the middle of an access (SECOND of LDI when enabled).
    mem_valid_in = 1'b1; mem_opcode_in = IND_EN ? LDI : LDR; mem_alu_in = 16'h4000;
    mem_dest_in = 3'd6; mem_ld_reg_in = 1'b1;
    dmem_resp = IND_EN; dmem_rdata = 16'h5002;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    #1;
    check("mid_read", 32'(dmem_read), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_read", 32'(dmem_read), 32'd0);
    check("rst_stall_mid", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check("rst_wb_valid_mid", 32'(wb_valid_out), 32'd0);
    mem_valid_in = 1'b0; reset_n = 1'b1; dmem_resp = 1'b1;   // late response
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check("late_resp_wb", 32'(wb_valid_out), 32'd0);
    run_op(1, LDR, 16'h2222, 16'h0, 3'd7, 1, 1, 16'hCAFE, 0, 16'h0);

    // Randomized ops.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op = 4'($urandom);
      logic       v  = ($urandom_range(0, 7) != 0);
      run_op(v, op, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
             $urandom_range(0, 3), 16'($urandom), $urandom_range(0, 3), 16'($urandom));
    end

    mem_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
